// File: rtl/vga_text_timing_if.sv
// vga_text_timing_if: text-buffer write port and pixel-slot outputs of vga_text_timing.
//   master: drives wr_en/wr_addr/wr_data, receives the video signals.
//   slave : the timing block; takes writes, drives hsync/vsync/en/character/dot_count/scan_count/frame_start.
interface vga_text_timing_if;
  logic       wr_en;
  logic [11:0] wr_addr;
  logic [3:0] wr_data;
  logic       hsync;
  logic       vsync;
  logic       en;
  logic [3:0] character;
  logic [2:0] dot_count;
  logic [3:0] scan_count;
  logic       frame_start;
  modport master (output wr_en, wr_addr, wr_data,
                  input hsync, vsync, en, character, dot_count, scan_count, frame_start);
  modport slave  (input wr_en, wr_addr, wr_data,
                  output hsync, vsync, en, character, dot_count, scan_count, frame_start);
endinterface

// File: rtl/vga_text_timing.sv
// vga_text_timing: VGA raster timing plus 80x30 4-bit text buffer feeding character_generator.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus (slave): wr_en/wr_addr/wr_data write port (cell = row*80+col, >=2400 ignored);
//                hsync/vsync (active low), en, character, dot_count, scan_count, frame_start,
//                all registered on pixel ticks and one tick behind the h/v counters.
module vga_text_timing #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input logic clk,
  input logic rst_n,
  vga_text_timing_if.slave bus
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int CELLS = 2400;
  logic [DW-1:0] div;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [11:0]   row, col, rd_addr;
  logic          tick, vis, h_end, v_end;
  logic [3:0]    ram [0:CELLS-1];
  assign tick    = div == DW'(CLK_DIV - 1);
  assign vis     = h < HW'(H_VISIBLE) && v < VW'(V_VISIBLE);
  assign h_end   = h == HW'(H_TOTAL - 1);
  assign v_end   = v == VW'(V_TOTAL - 1);
  assign row     = 12'(v >> 4);
  assign col     = 12'(h >> 3);
  // row*80 built from shifts so no multiplier is inferred
  assign rd_addr = (row << 6) + (row << 4) + col;
  // Buffer contents survive reset, so writes are independent of rst_n
  always_ff @(posedge clk)
    if (bus.wr_en && bus.wr_addr < 12'(CELLS)) ram[bus.wr_addr] <= bus.wr_data;
  // The RAM read register doubles as the character output register, which keeps
  // character aligned with the other outputs decoded from the same h/v
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div             <= '0;
      h               <= '0;
      v               <= '0;
      bus.hsync       <= 1'b1;
      bus.vsync       <= 1'b1;
      bus.en          <= 1'b0;
      bus.character   <= '0;
      bus.dot_count   <= '0;
      bus.scan_count  <= '0;
      bus.frame_start <= 1'b0;
    end else begin
      div             <= tick ? '0 : div + 1'b1;
      bus.frame_start <= tick && h == '0 && v == '0;
      if (tick) begin
        h              <= h_end ? '0 : h + 1'b1;
        if (h_end) v   <= v_end ? '0 : v + 1'b1;
        bus.hsync      <= !(h >= HW'(H_VISIBLE + H_FRONT) && h < HW'(H_VISIBLE + H_FRONT + H_SYNC));
        bus.vsync      <= !(v >= VW'(V_VISIBLE + V_FRONT) && v < VW'(V_VISIBLE + V_FRONT + V_SYNC));
        bus.en         <= vis;
        bus.dot_count  <= h[2:0];
        bus.scan_count <= v[3:0];
        bus.character  <= vis ? ram[rd_addr] : '0;
      end
    end
endmodule

// File: tb/tb_vga_text_timing.sv
// tb_vga_text_timing: random-write bench for vga_text_timing against a pixel-index reference model.
module tb_vga_text_timing;
  localparam int D  = 2;
  localparam int HV = 64, HF = 2, HS = 4, HB = 2;
  localparam int VV = 64, VF = 2, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT * D;
  logic clk, rst_n;
  int vectors, miscompares;
  bit chk;
  vga_text_timing_if bus();
  vga_text_timing #(
    .CLK_DIV(D), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  // Reference: the c-th clock after release is a tick when c is a multiple of D and
  // loads pixel n = c/D-1, whose h/v come from plain division of n by the raster size.
  logic [3:0] mram [0:2399];
  int c;
  logic e_hs, e_vs, e_en, e_fs;
  logic [3:0] e_ch, e_sc;
  logic [2:0] e_dc;
  always @(posedge clk or negedge rst_n) begin
    int n, h, v;
    bit vis;
    if (!rst_n) begin
      c <= 0;
      e_hs <= 1; e_vs <= 1; e_en <= 0; e_fs <= 0; e_ch <= 0; e_dc <= 0; e_sc <= 0;
    end else begin
      c <= c + 1;
      e_fs <= 0;
      if ((c + 1) % D == 0) begin
        n = (c + 1) / D - 1;
        h = n % HT;
        v = (n / HT) % VT;
        vis = h < HV && v < VV;
        e_en <= vis;
        e_hs <= !(h >= HV + HF && h < HV + HF + HS);
        e_vs <= !(v >= VV + VF && v < VV + VF + VS);
        e_dc <= 3'(h % 8);
        e_sc <= 4'(v % 16);
        e_ch <= vis ? mram[(v / 16) * 80 + h / 8] : 4'd0;
        e_fs <= n % (HT * VT) == 0;
      end
    end
  end
  always @(posedge clk)
    if (bus.wr_en && bus.wr_addr < 12'd2400) mram[bus.wr_addr] <= bus.wr_data;
  always @(negedge clk)
    if (chk) begin
      vectors++;
      if ({bus.hsync, bus.vsync, bus.en, bus.frame_start, bus.character, bus.dot_count, bus.scan_count} !==
          {e_hs, e_vs, e_en, e_fs, e_ch, e_dc, e_sc}) begin
        miscompares++;
        $display("FAIL cycle t=%0t: got hs=%b vs=%b en=%b fs=%b ch=%h dc=%0d sc=%0d, expected hs=%b vs=%b en=%b fs=%b ch=%h dc=%0d sc=%0d",
                 $time, bus.hsync, bus.vsync, bus.en, bus.frame_start, bus.character, bus.dot_count, bus.scan_count,
                 e_hs, e_vs, e_en, e_fs, e_ch, e_dc, e_sc);
      end
    end
  // Per-frame statistics gathered from the DUT outputs, checked against literal values
  int cyc, last_fs, rel, first_hs, gap, cnt_en, cnt_hs, cnt_vs, fr_en, fr_hs, fr_vs, fr_hf;
  bit have, seen;
  always @(negedge clk) begin
    int r;
    r = bus.frame_start ? 0 : rel + 1;
    cyc <= cyc + 1;
    rel <= r;
    if (!rst_n) have <= 0;
    else if (bus.frame_start) begin
      if (have) begin
        gap <= cyc - last_fs; fr_en <= cnt_en; fr_hs <= cnt_hs; fr_vs <= cnt_vs; fr_hf <= first_hs;
      end
      have <= 1;
      last_fs <= cyc;
    end
    cnt_en <= (bus.frame_start ? 0 : cnt_en) + int'(bus.en === 1'b1);
    cnt_hs <= (bus.frame_start ? 0 : cnt_hs) + int'(bus.hsync === 1'b0);
    cnt_vs <= (bus.frame_start ? 0 : cnt_vs) + int'(bus.vsync === 1'b0);
    if (bus.frame_start) seen <= 0;
    else if (bus.hsync === 1'b0 && !seen) begin
      seen <= 1;
      first_hs <= r;
    end
  end
  task automatic pin(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic wait_fs;
    for (int i = 0; i < FRAME + 100 && bus.frame_start !== 1'b1; i++) @(negedge clk);
    if (bus.frame_start !== 1'b1) pin("fs_timeout", 0, 1);
  endtask
  task automatic wr(input int a, input int d);
    bus.wr_en = 1;
    bus.wr_addr = 12'(a);
    bus.wr_data = 4'(d);
  endtask
  initial begin
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
    rst_n = 1;
    #1 rst_n = 0;
    #1 chk = 1;
    for (int i = 0; i < 2400; i++) begin
      @(negedge clk);
      wr(i, i == 0 ? 'hA : i == 247 ? 'h5 : i == 81 ? 'h7 : int'($urandom_range(0, 15)));
    end
    @(negedge clk);
    bus.wr_en = 0;
    rst_n = 1;
    repeat (2) @(negedge clk);
    pin("first_fs", bus.frame_start, 1);
    pin("first_en", bus.en, 1);
    pin("first_dot", bus.dot_count, 0);
    pin("first_scan", bus.scan_count, 0);
    pin("cell0_char", bus.character, 'hA);
    repeat (2 * 1160 - 1) @(negedge clk);
    wr(81, 'h3);
    @(negedge clk);
    bus.wr_en = 0;
    pin("collide_old_char", bus.character, 'h7);
    pin("collide_dot", bus.dot_count, 0);
    pin("collide_scan", bus.scan_count, 0);
    repeat (2 * (4599 - 1160)) @(negedge clk);
    pin("last_cell_char", bus.character, 'h5);
    pin("last_cell_dot", bus.dot_count, 7);
    pin("last_cell_scan", bus.scan_count, 15);
    repeat (2) @(negedge clk);
    pin("blank_char", bus.character, 0);
    pin("blank_en", bus.en, 0);
    repeat (FRAME + 2 * 1160 - 2 * 4600) @(negedge clk);
    pin("collide_new_char", bus.character, 'h3);
    for (int i = 0; i < 2 * FRAME; i++) begin
      int sel;
      @(negedge clk);
      sel = int'($urandom_range(0, 3));
      bus.wr_en = $urandom_range(0, 3) == 0;
      bus.wr_addr = sel == 0 ? 12'($urandom_range(0, 3) * 80 + $urandom_range(0, 7)) :
                    sel == 1 ? ($urandom_range(0, 1) == 1 ? 12'd2400 : 12'd4095) : 12'($urandom);
      bus.wr_data = 4'($urandom);
    end
    @(negedge clk);
    bus.wr_en = 0;
    pin("frame_period", gap, FRAME);
    pin("en_cycles", fr_en, HV * VV * D);
    pin("hsync_low_cycles", fr_hs, HS * VT * D);
    pin("vsync_low_cycles", fr_vs, VS * HT * D);
    pin("hsync_fall_offset", fr_hf, (HV + HF) * D);
    wait_fs;
    repeat (2 * (20 * HT + 30)) @(negedge clk);
    pin("mid_dot", bus.dot_count, 6);
    pin("mid_scan", bus.scan_count, 4);
    pin("mid_en", bus.en, 1);
    #2 rst_n = 0;
    #1;
    pin("rst_hsync", bus.hsync, 1);
    pin("rst_vsync", bus.vsync, 1);
    pin("rst_en", bus.en, 0);
    pin("rst_char", bus.character, 0);
    pin("rst_dot", bus.dot_count, 0);
    pin("rst_scan", bus.scan_count, 0);
    pin("rst_fs", bus.frame_start, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    pin("restart_fs", bus.frame_start, 1);
    pin("restart_en", bus.en, 1);
    pin("restart_dot", bus.dot_count, 0);
    pin("restart_scan", bus.scan_count, 0);
    repeat (200) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
